// File: rtl/therm_pkg.sv
// Shared helpers for the thermometer/binary conversion blocks (bin2therm, therm2bin_pipe).
package therm_pkg;

  localparam int unsigned MAX_N_BIT = 8;
  localparam int unsigned MAX_TH    = 2**MAX_N_BIT - 1;

  // Thermometer width for an n-bit code.
  function automatic int unsigned n_th(input int unsigned n);
    return (2**n) - 1;
  endfunction

  // Callers zero-extend their N_TH-wide word and truncate the result to N_BIT.
  function automatic int unsigned popcount(input logic [MAX_TH-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_TH; i++) begin
      c = c + int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/therm_bubble_fix.sv
// Single-bubble correction: 3-input majority per bit, plus a flag for any non-thermometer input.
module therm_bubble_fix #(
  parameter int unsigned N_TH = 31
) (
  input  logic [N_TH-1:0] raw,
  output logic [N_TH-1:0] corr,
  output logic            err
);

  // ext[0] stands for t[-1]=1 and ext[N_TH+1] for t[N_TH]=0.
  logic [N_TH+1:0] ext;

  always_comb begin
    ext  = {1'b0, raw, 1'b1};
    corr = '0;
    for (int i = 0; i < N_TH; i++) begin
      corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
    // corr is a thermometer iff corr+1 is a power of two (all-ones wraps to zero).
    err = (raw != corr) || ((corr & (corr + N_TH'(1))) != '0);
  end

endmodule

// File: rtl/therm2bin_pipe.sv
// Two-stage thermometer-to-binary decoder with valid/ready flow control and a bubble counter.
module therm2bin_pipe
  import therm_pkg::*;
#(
  parameter int unsigned N_BIT = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [n_th(N_BIT)-1:0]   in_therm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_BIT-1:0]         out_code,
  output logic                     out_err,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int unsigned      N_TH    = n_th(N_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            s1_valid_q;
  logic [N_TH-1:0] s1_corr_q;
  logic            s1_err_q;
  logic            out_valid_q;
  logic [N_BIT-1:0] out_code_q;
  logic            out_err_q;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [N_TH-1:0] fix_corr;
  logic            fix_err;
  logic            s1_load, s2_load;
  logic [N_BIT-1:0] code_d;

  therm_bubble_fix #(
    .N_TH (N_TH)
  ) u_fix (
    .raw  (in_therm),
    .corr (fix_corr),
    .err  (fix_err)
  );

  // No skid buffer: in_ready is combinational from out_ready through s2_load.
  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;
    code_d   = N_BIT'(popcount(MAX_TH'(s1_corr_q)));
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (out_valid_q && out_ready && out_err_q && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_valid_q <= 1'b0;
      s1_corr_q  <= '0;
      s1_err_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_corr_q <= fix_corr;
        s1_err_q  <= fix_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_code_q <= code_d;
        out_err_q  <= s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
